// File: rtl/fetch_unit.sv
// fetch_unit: owns PC, instruction register and EPC for the multicycle core.
// Fetches over a ready/valid instruction-memory handshake with variable
// latency, vectors exceptions through handler-pointer words, and faults
// permanently on bus error or request timeout.
//
// Ports:
//   clock, reset            rising-edge clock, asynchronous active-low reset
//   imem_req_o/addr_o       fetch request and address (held until ready)
//   imem_ready_i/rdata_i    memory accept + return data in the same cycle
//   imem_err_i              bus error, qualified by imem_ready_i
//   ir_o/ir_valid_o         instruction register and its valid flag
//   ir_ack_i                datapath consumed ir_o
//   pc_wr_i/pc_next_i       redirect request and target (with ack)
//   exc_i                   01 illegal, 10 overflow, 00/11 none
//   pc_o/epc_o              current PC and faulting PC
//   fault_o                 sticky fetch fault
//
// Optional feature (macro FETCH_EXC_CAUSE_EN):
//   cause_o[1:0]            cause of the most recent vector (01/10/11)
//   exc_cnt_o[7:0]          saturating count of vector entries
module fetch_unit #(
  parameter int unsigned     XLEN     = 64,
  parameter int unsigned     IADDR_W  = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     VEC_ILL  = 254,
  parameter int unsigned     VEC_OVF  = 255,
  parameter int unsigned     VEC_MIS  = 253,
  parameter int unsigned     TIMEOUT  = 15
) (
  input  logic               clock,
  input  logic               reset,
  output logic               imem_req_o,
  output logic [IADDR_W-1:0] imem_addr_o,
  input  logic               imem_ready_i,
  input  logic [31:0]        imem_rdata_i,
  input  logic               imem_err_i,
  output logic [31:0]        ir_o,
  output logic               ir_valid_o,
  input  logic               ir_ack_i,
  input  logic               pc_wr_i,
  input  logic [XLEN-1:0]    pc_next_i,
  input  logic [1:0]         exc_i,
  output logic [XLEN-1:0]    pc_o,
  output logic [XLEN-1:0]    epc_o,
  output logic               fault_o
`ifdef FETCH_EXC_CAUSE_EN
  ,
  output logic [1:0]         cause_o,
  output logic [7:0]         exc_cnt_o
`endif
);

  localparam int unsigned     CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_HOLD   = 2'd1,
    S_VECTOR = 2'd2,
    S_FAULT  = 2'd3
  } state_t;

  state_t             r_state;
  logic               r_req;
  logic [IADDR_W-1:0] r_addr;
  logic [31:0]        r_ir;
  logic               r_ir_valid;
  logic [XLEN-1:0]    r_pc;
  logic [XLEN-1:0]    r_epc;
  logic               r_fault;
  logic [CNT_W-1:0]   r_wait_cnt;
`ifdef FETCH_EXC_CAUSE_EN
  logic [1:0]         r_cause;
  logic [7:0]         r_exc_cnt;
`endif

  logic               w_take_exc;
  logic               w_misalign;
  logic [IADDR_W-1:0] w_vec_addr;
  logic [1:0]         w_cause;
  logic [XLEN-1:0]    w_pc_inc;
  logic [XLEN-1:0]    w_vec_pc;

  // Exception / misaligned-redirect decode used while in HOLD.
  always_comb begin
    w_take_exc = (exc_i == 2'b01) || (exc_i == 2'b10);
    w_misalign = ir_ack_i && pc_wr_i && (pc_next_i[1:0] != 2'b00);
    w_vec_addr = IADDR_W'(VEC_MIS);
    w_cause    = 2'b11;
    if (exc_i == 2'b01) begin
      w_vec_addr = IADDR_W'(VEC_ILL);
      w_cause    = 2'b01;
    end else if (exc_i == 2'b10) begin
      w_vec_addr = IADDR_W'(VEC_OVF);
      w_cause    = 2'b10;
    end
  end

  assign w_pc_inc = r_pc + XLEN'(4);
  assign w_vec_pc = XLEN'(imem_rdata_i);

  // Fetch FSM with registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= S_FETCH;
      r_req      <= 1'b0;
      r_addr     <= RESET_PC[IADDR_W-1:0];
      r_ir       <= 32'd0;
      r_ir_valid <= 1'b0;
      r_pc       <= RESET_PC;
      r_epc      <= '0;
      r_fault    <= 1'b0;
      r_wait_cnt <= '0;
`ifdef FETCH_EXC_CAUSE_EN
      r_cause    <= 2'b00;
      r_exc_cnt  <= 8'd0;
`endif
    end else begin
      case (r_state)
        S_FETCH, S_VECTOR: begin
          if (!r_req) begin
            // First cycle out of reset: raise the request.
            r_req <= 1'b1;
          end else if (imem_ready_i) begin
            r_wait_cnt <= '0;
            if (imem_err_i) begin
              r_state <= S_FAULT;
              r_req   <= 1'b0;
              r_fault <= 1'b1;
            end else if (r_state == S_FETCH) begin
              r_ir       <= imem_rdata_i;
              r_ir_valid <= 1'b1;
              r_req      <= 1'b0;
              r_state    <= S_HOLD;
            end else begin
              // Handler pointer read: jump there and keep requesting.
              r_pc    <= w_vec_pc;
              r_addr  <= w_vec_pc[IADDR_W-1:0];
              r_state <= S_FETCH;
            end
          end else if (r_wait_cnt == CNT_LAST) begin
            r_state <= S_FAULT;
            r_req   <= 1'b0;
            r_fault <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
          end
        end

        S_HOLD: begin
          if (w_take_exc || w_misalign) begin
            // Exceptions outrank the ack in the same cycle.
            r_epc      <= r_pc;
            r_ir_valid <= 1'b0;
            r_req      <= 1'b1;
            r_addr     <= w_vec_addr;
            r_state    <= S_VECTOR;
`ifdef FETCH_EXC_CAUSE_EN
            r_cause    <= w_cause;
            if (r_exc_cnt != 8'hFF) begin
              r_exc_cnt <= r_exc_cnt + 8'd1;
            end
`endif
          end else if (ir_ack_i && pc_wr_i) begin
            r_pc       <= pc_next_i;
            r_addr     <= pc_next_i[IADDR_W-1:0];
            r_ir_valid <= 1'b0;
            r_req      <= 1'b1;
            r_state    <= S_FETCH;
          end else if (ir_ack_i) begin
            r_pc       <= w_pc_inc;
            r_addr     <= w_pc_inc[IADDR_W-1:0];
            r_ir_valid <= 1'b0;
            r_req      <= 1'b1;
            r_state    <= S_FETCH;
          end
        end

        S_FAULT: begin
          r_req      <= 1'b0;
          r_ir_valid <= 1'b0;
          r_fault    <= 1'b1;
        end

        default: r_state <= S_FAULT;
      endcase
    end
  end

`ifndef FETCH_EXC_CAUSE_EN
  // Cause decode only feeds the optional cause register.
  logic w_unused_cause;
  assign w_unused_cause = ^w_cause;
`endif

  assign imem_req_o  = r_req;
  assign imem_addr_o = r_addr;
  assign ir_o        = r_ir;
  assign ir_valid_o  = r_ir_valid;
  assign pc_o        = r_pc;
  assign epc_o       = r_epc;
  assign fault_o     = r_fault;
`ifdef FETCH_EXC_CAUSE_EN
  assign cause_o     = r_cause;
  assign exc_cnt_o   = r_exc_cnt;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized
// sequence of HOLD events checked against a PC/EPC-level reference model.
module tb_fetch_unit;

  localparam int unsigned XLEN    = 64;
  localparam int unsigned IADDR_W = 32;
  localparam int unsigned TIMEOUT = 15;
  localparam logic [31:0] VEC_ILL = 32'd254;
  localparam logic [31:0] VEC_OVF = 32'd255;
  localparam logic [31:0] VEC_MIS = 32'd253;

  logic               clock = 1'b0;
  logic               reset = 1'b0;
  logic               imem_req_o;
  logic [IADDR_W-1:0] imem_addr_o;
  logic               imem_ready_i = 1'b0;
  logic [31:0]        imem_rdata_i = 32'd0;
  logic               imem_err_i = 1'b0;
  logic [31:0]        ir_o;
  logic               ir_valid_o;
  logic               ir_ack_i = 1'b0;
  logic               pc_wr_i = 1'b0;
  logic [XLEN-1:0]    pc_next_i = '0;
  logic [1:0]         exc_i = 2'b00;
  logic [XLEN-1:0]    pc_o;
  logic [XLEN-1:0]    epc_o;
  logic               fault_o;
`ifdef FETCH_EXC_CAUSE_EN
  logic [1:0]         cause_o;
  logic [7:0]         exc_cnt_o;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [63:0] m_pc, m_epc;
  logic [31:0] m_ir;
  logic [1:0]  m_cause;
  int          m_cnt;

  fetch_unit #(
    .XLEN(XLEN), .IADDR_W(IADDR_W), .RESET_PC('0),
    .VEC_ILL(254), .VEC_OVF(255), .VEC_MIS(253), .TIMEOUT(TIMEOUT)
  ) dut (
    .clock(clock), .reset(reset),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_ready_i(imem_ready_i), .imem_rdata_i(imem_rdata_i), .imem_err_i(imem_err_i),
    .ir_o(ir_o), .ir_valid_o(ir_valid_o), .ir_ack_i(ir_ack_i),
    .pc_wr_i(pc_wr_i), .pc_next_i(pc_next_i), .exc_i(exc_i),
    .pc_o(pc_o), .epc_o(epc_o), .fault_o(fault_o)
`ifdef FETCH_EXC_CAUSE_EN
    , .cause_o(cause_o), .exc_cnt_o(exc_cnt_o)
`endif
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_side(input string tag);
`ifdef FETCH_EXC_CAUSE_EN
    check({tag, "_cause"}, 64'(cause_o), 64'(m_cause));
    check({tag, "_exccnt"}, 64'(exc_cnt_o), 64'(m_cnt));
`else
    check({tag, "_fault"}, 64'(fault_o), 64'd0);
`endif
  endtask

  // Wait (bounded) for a request, then answer after lat wait cycles.
  // Junk datapath inputs during the wait must be ignored outside HOLD.
  task automatic serve(input string tag, input logic [31:0] exp_addr, input int lat,
                       input logic [31:0] data, input logic err);
    int guard;
    guard = 0;
    while (imem_req_o !== 1'b1 && guard < 8) begin
      step();
      guard++;
    end
    check({tag, "_req"}, 64'(imem_req_o), 64'd1);
    check({tag, "_addr"}, 64'(imem_addr_o), 64'(exp_addr));
    for (int i = 0; i < lat; i++) begin
      imem_ready_i = 1'b0;
      ir_ack_i     = 1'($urandom);
      pc_wr_i      = 1'($urandom);
      exc_i        = 2'($urandom);
      pc_next_i    = {$urandom, $urandom};
      step();
      check({tag, "_waitaddr"}, 64'(imem_addr_o), 64'(exp_addr));
    end
    ir_ack_i     = 1'b0;
    pc_wr_i      = 1'b0;
    exc_i        = 2'b00;
    imem_ready_i = 1'b1;
    imem_rdata_i = data;
    imem_err_i   = err;
    step();
    imem_ready_i = 1'b0;
    imem_err_i   = 1'b0;
    imem_rdata_i = $urandom;
  endtask

  task automatic hold_op(input logic ack, input logic wr, input logic [63:0] nxt,
                         input logic [1:0] exc);
    ir_ack_i  = ack;
    pc_wr_i   = wr;
    pc_next_i = nxt;
    exc_i     = exc;
    step();
    ir_ack_i  = 1'b0;
    pc_wr_i   = 1'b0;
    exc_i     = 2'b00;
  endtask

  task automatic fetch_ok(input string tag, input int lat);
    logic [31:0] d;
    d = $urandom;
    serve(tag, m_pc[31:0], lat, d, 1'b0);
    m_ir = d;
    check({tag, "_ir"}, 64'(ir_o), 64'(m_ir));
    check({tag, "_valid"}, 64'(ir_valid_o), 64'd1);
    check({tag, "_pc"}, pc_o, m_pc);
    check({tag, "_epc"}, epc_o, m_epc);
    check({tag, "_reqoff"}, 64'(imem_req_o), 64'd0);
  endtask

  task automatic enter_vector(input string tag, input logic [1:0] cause, input logic [31:0] vec);
    m_cause = cause;
    if (m_cnt < 255) m_cnt++;
    check({tag, "_vvalid"}, 64'(ir_valid_o), 64'd0);
    check({tag, "_vepc"}, epc_o, m_epc);
    check({tag, "_vpc"}, pc_o, m_pc);
    check({tag, "_vaddr"}, 64'(imem_addr_o), 64'(vec));
    check_side(tag);
  endtask

  task automatic vector_ok(input string tag, input logic [31:0] vec, input int lat,
                           input logic [31:0] handler);
    serve(tag, vec, lat, handler, 1'b0);
    m_pc = 64'(handler);
    check({tag, "_hpc"}, pc_o, m_pc);
    check({tag, "_hreq"}, 64'(imem_req_o), 64'd1);
    check({tag, "_haddr"}, 64'(imem_addr_o), 64'(handler));
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
    m_pc = '0; m_epc = '0; m_ir = '0; m_cause = 2'b00; m_cnt = 0;
  endtask

  initial begin
    logic [63:0] tgt;
    logic [31:0] h;
    logic [1:0]  e;
    int          n;
    int          op;
    int          lat;

    // Reset values
    m_pc = '0; m_epc = '0; m_ir = '0; m_cause = 2'b00; m_cnt = 0;
    repeat (3) step();
    check("rst_pc", pc_o, 64'd0);
    check("rst_ir", 64'(ir_o), 64'd0);
    check("rst_valid", 64'(ir_valid_o), 64'd0);
    check("rst_req", 64'(imem_req_o), 64'd0);
    check("rst_epc", epc_o, 64'd0);
    check("rst_fault", 64'(fault_o), 64'd0);
    check_side("rst");

    // First fetch: req in cycle 1, ready in cycle 3
    reset = 1'b1;
    check("c0_req", 64'(imem_req_o), 64'd0);
    step();
    check("c1_req", 64'(imem_req_o), 64'd1);
    check("c1_addr", 64'(imem_addr_o), 64'd0);
    serve("first", 32'd0, 2, 32'h0000_0013, 1'b0);
    m_ir = 32'h13;
    check("first_ir", 64'(ir_o), 64'h13);
    check("first_valid", 64'(ir_valid_o), 64'd1);
    check("first_pc", pc_o, 64'd0);

    // Sequential acks with 0-wait memory
    for (int k = 1; k <= 3; k++) begin
      hold_op(1'b1, 1'b0, 64'd0, 2'b00);
      check("seq_valid_drop", 64'(ir_valid_o), 64'd0);
      m_pc = m_pc + 64'd4;
      fetch_ok("seq", 0);
      check("seq_pc", pc_o, 64'(4 * k));
    end

    // Wrap at top of address space
    tgt = 64'hFFFF_FFFF_FFFF_FFFC;
    hold_op(1'b1, 1'b1, tgt, 2'b00);
    m_pc = tgt;
    fetch_ok("wraptop", 0);
    hold_op(1'b1, 1'b0, 64'd0, 2'b00);
    m_pc = 64'd0;
    fetch_ok("wrap0", 0);

    // Overflow exception with simultaneous ack
    hold_op(1'b1, 1'b1, 64'h40, 2'b00);
    m_pc = 64'h40;
    fetch_ok("to40", 1);
    m_epc = m_pc;
    hold_op(1'b1, 1'b0, 64'd0, 2'b10);
    enter_vector("ovf", 2'b10, VEC_OVF);
    vector_ok("ovf", VEC_OVF, 1, 32'h80);
    fetch_ok("ovf_fetch", 0);

    // Misaligned redirect, then aligned redirect
    m_epc = m_pc;
    hold_op(1'b1, 1'b1, 64'h102, 2'b00);
    enter_vector("mis", 2'b11, VEC_MIS);
    vector_ok("mis", VEC_MIS, 0, 32'h300);
    fetch_ok("mis_fetch", 2);
    hold_op(1'b1, 1'b1, 64'h100, 2'b00);
    m_pc = 64'h100;
    fetch_ok("redir100", 0);

    // Idle HOLD: nothing moves
    repeat (3) begin
      hold_op(1'b0, 1'b1, 64'h2, 2'b11);
      check("idle_valid", 64'(ir_valid_o), 64'd1);
      check("idle_pc", pc_o, m_pc);
      check("idle_ir", 64'(ir_o), 64'(m_ir));
      check("idle_req", 64'(imem_req_o), 64'd0);
    end

    // Randomized HOLD events against the reference model
    for (int it = 0; it < 40; it++) begin
      op  = $urandom_range(0, 5);
      lat = $urandom_range(0, 3);
      case (op)
        0: begin
          hold_op(1'b0, 1'($urandom), {$urandom, $urandom}, 2'b00);
          check("r_idle_pc", pc_o, m_pc);
          check("r_idle_ir", 64'(ir_o), 64'(m_ir));
          check("r_idle_valid", 64'(ir_valid_o), 64'd1);
        end
        1, 5: begin
          hold_op(1'b1, 1'b0, {$urandom, $urandom}, (op == 5) ? 2'b11 : 2'b00);
          m_pc = m_pc + 64'd4;
          fetch_ok("r_inc", lat);
        end
        2: begin
          tgt = {$urandom, $urandom} & ~64'd3;
          hold_op(1'b1, 1'b1, tgt, 2'b00);
          m_pc = tgt;
          fetch_ok("r_jmp", lat);
        end
        3: begin
          tgt = {$urandom, $urandom};
          tgt[1:0] = 2'($urandom_range(1, 3));
          m_epc = m_pc;
          hold_op(1'b1, 1'b1, tgt, 2'b00);
          enter_vector("r_mis", 2'b11, VEC_MIS);
          h = $urandom & ~32'd3;
          vector_ok("r_mis", VEC_MIS, lat, h);
          fetch_ok("r_mis_fetch", $urandom_range(0, 3));
        end
        default: begin
          e = 2'($urandom_range(1, 2));
          m_epc = m_pc;
          hold_op(1'($urandom), 1'($urandom), {$urandom, $urandom}, e);
          enter_vector("r_exc", e, (e == 2'b01) ? VEC_ILL : VEC_OVF);
          h = $urandom & ~32'd3;
          vector_ok("r_exc", (e == 2'b01) ? VEC_ILL : VEC_OVF, lat, h);
          fetch_ok("r_exc_fetch", $urandom_range(0, 3));
        end
      endcase
    end

    // Reset pulled during a VECTOR wait
    m_epc = m_pc;
    hold_op(1'b0, 1'b0, 64'd0, 2'b01);
    enter_vector("rv", 2'b01, VEC_ILL);
    step();
    step();
    reset = 1'b0;
    #1;
    check("arst_pc", pc_o, 64'd0);
    check("arst_ir", 64'(ir_o), 64'd0);
    check("arst_valid", 64'(ir_valid_o), 64'd0);
    check("arst_req", 64'(imem_req_o), 64'd0);
    check("arst_epc", epc_o, 64'd0);
    check("arst_fault", 64'(fault_o), 64'd0);
    m_cause = 2'b00; m_cnt = 0;
    check_side("arst");
    step();
    reset = 1'b1;
    m_pc = '0; m_epc = '0;
    step();
    check("refetch_req", 64'(imem_req_o), 64'd1);
    fetch_ok("refetch", 1);

    // Memory never ready: timeout fault
    do_reset();
    step();
    check("to_req", 64'(imem_req_o), 64'd1);
    n = 0;
    while (fault_o !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    check("to_cycles", 64'(n), 64'(TIMEOUT));
    check("to_reqoff", 64'(imem_req_o), 64'd0);
    imem_ready_i = 1'b1;
    repeat (3) step();
    imem_ready_i = 1'b0;
    check("to_sticky", 64'(fault_o), 64'd1);
    check("to_sticky_req", 64'(imem_req_o), 64'd0);
    check("to_sticky_valid", 64'(ir_valid_o), 64'd0);

    // Bus error on instruction fetch
    do_reset();
    serve("berr", 32'd0, 1, 32'hDEAD_BEEF, 1'b1);
    check("berr_fault", 64'(fault_o), 64'd1);
    check("berr_req", 64'(imem_req_o), 64'd0);
    check("berr_valid", 64'(ir_valid_o), 64'd0);
    check("berr_ir", 64'(ir_o), 64'd0);

    // Bus error on handler-pointer read
    do_reset();
    fetch_ok("vberr_pre", 0);
    m_epc = m_pc;
    hold_op(1'b0, 1'b0, 64'd0, 2'b01);
    enter_vector("vberr", 2'b01, VEC_ILL);
    serve("vberr", VEC_ILL, 0, 32'h1234, 1'b1);
    check("vberr_fault", 64'(fault_o), 64'd1);
    check("vberr_req", 64'(imem_req_o), 64'd0);
    check("vberr_pc", pc_o, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
